// File: rtl/rgb2yuv_pkg.sv
// rgb2yuv_pkg: BT.601 full-range coefficients, offsets, shift, latency and clamp helper
package rgb2yuv_pkg;
  localparam int K_YR = 77;
  localparam int K_YG = 150;
  localparam int K_YB = 29;
  localparam int K_UR = -43;
  localparam int K_UG = -85;
  localparam int K_UB = 128;
  localparam int K_VR = 128;
  localparam int K_VG = -107;
  localparam int K_VB = -21;
  localparam int OFF_Y = 128;
  localparam int OFF_C = 32896;
  localparam int FRAC = 8;
  localparam int LAT = 3;
  typedef logic signed [19:0] acc_t;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
  function automatic logic [7:0] clamp8(input acc_t s);
    acc_t q;
    q = s >>> FRAC;
    return (q < 20'sd0) ? 8'd0 : (q > 20'sd255) ? 8'd255 : q[7:0];
  endfunction
endpackage

// File: rtl/rgb2yuv_if.sv
// rgb2yuv_if: video stream in (sync, enable, pixel) and YUV stream out
interface rgb2yuv_if;
  logic vs_i;
  logic de_i;
  logic [23:0] rgb_i;
  logic vs_o;
  logic de_o;
  logic [7:0] y_ch_o;
  logic [7:0] u_ch_o;
  logic [7:0] v_ch_o;
  modport master (output vs_i, de_i, rgb_i, input vs_o, de_o, y_ch_o, u_ch_o, v_ch_o);
  modport slave (input vs_i, de_i, rgb_i, output vs_o, de_o, y_ch_o, u_ch_o, v_ch_o);
endinterface

// File: rtl/rgb2yuv_dot3.sv
// rgb2yuv_dot3: two-stage signed 3-term MAC with offset, then shift and clamp to 8 bits
module rgb2yuv_dot3
  import rgb2yuv_pkg::*;
#(
  parameter int KA = 0,
  parameter int KB = 0,
  parameter int KC = 0,
  parameter int OFF = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  output logic [7:0] res
);
  acc_t p0, p1, p2, sum;
  // stage 1 registers the products, stage 2 the offset sum
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p0 <= '0;
      p1 <= '0;
      p2 <= '0;
      sum <= '0;
    end else begin
      p0 <= acc_t'({12'd0, a}) * acc_t'(KA);
      p1 <= acc_t'({12'd0, b}) * acc_t'(KB);
      p2 <= acc_t'({12'd0, c}) * acc_t'(KC);
      sum <= p0 + p1 + p2 + acc_t'(OFF);
    end
  end
  assign res = clamp8(sum);
endmodule

// File: rtl/rgb2yuv.sv
// rgb2yuv: 3-stage RGB to YUV converter with optional 4:2:2 interleaved chroma
module rgb2yuv
  import rgb2yuv_pkg::*;
#(
  parameter bit CHROMA_422 = 1'b0
) (
  input logic clk_i,
  input logic rst_n_i,
  rgb2yuv_if.slave io
);
  rgb_t px;
  logic [7:0] y, u, v;
  logic [LAT-2:0] vs_d, de_d, ph_d;
  logic phase, cur_ph;
  assign px = io.rgb_i;
  // a fresh line (de_d[0] holds last cycle's de_i) always starts on Cb
  assign cur_ph = (io.de_i && !de_d[0]) ? 1'b0 : phase;
  rgb2yuv_dot3 #(.KA(K_YR), .KB(K_YG), .KC(K_YB), .OFF(OFF_Y)) u_y (
    .clk(clk_i), .rst_n(rst_n_i), .a(px.r), .b(px.g), .c(px.b), .res(y));
  rgb2yuv_dot3 #(.KA(K_UR), .KB(K_UG), .KC(K_UB), .OFF(OFF_C)) u_u (
    .clk(clk_i), .rst_n(rst_n_i), .a(px.r), .b(px.g), .c(px.b), .res(u));
  rgb2yuv_dot3 #(.KA(K_VR), .KB(K_VG), .KC(K_VB), .OFF(OFF_C)) u_v (
    .clk(clk_i), .rst_n(rst_n_i), .a(px.r), .b(px.g), .c(px.b), .res(v));
  // delay lines, phase tracking and the blanking-forced output stage
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      vs_d <= '0;
      de_d <= '0;
      ph_d <= '0;
      phase <= 1'b0;
      io.vs_o <= 1'b0;
      io.de_o <= 1'b0;
      io.y_ch_o <= 8'd0;
      io.u_ch_o <= 8'd128;
      io.v_ch_o <= 8'd128;
    end else begin
      vs_d <= {vs_d[LAT-3:0], io.vs_i};
      de_d <= {de_d[LAT-3:0], io.de_i};
      ph_d <= {ph_d[LAT-3:0], cur_ph};
      if (io.de_i) phase <= ~cur_ph;
      io.vs_o <= vs_d[LAT-2];
      io.de_o <= de_d[LAT-2];
      io.y_ch_o <= de_d[LAT-2] ? y : 8'd0;
      io.u_ch_o <= !de_d[LAT-2] ? 8'd128 : (CHROMA_422 && ph_d[LAT-2]) ? v : u;
      io.v_ch_o <= (!de_d[LAT-2] || CHROMA_422) ? 8'd128 : v;
    end
  end
endmodule

// File: tb/tb_rgb2yuv.sv
// tb_rgb2yuv: directed checks of both 4:4:4 and 4:2:2 builds of rgb2yuv
module tb_rgb2yuv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vs = 1'b0;
  logic de = 1'b0;
  logic [23:0] rgb = '0;
  logic [2:0] vs_h = '0;
  logic [2:0] de_h = '0;
  int n_chk = 0;
  int n_fail = 0;

  rgb2yuv_if a ();
  rgb2yuv_if b ();
  assign a.vs_i = vs;
  assign a.de_i = de;
  assign a.rgb_i = rgb;
  assign b.vs_i = vs;
  assign b.de_i = de;
  assign b.rgb_i = rgb;

  rgb2yuv #(.CHROMA_422(1'b0)) dut (.clk_i(clk), .rst_n_i(rst_n), .io(a));
  rgb2yuv #(.CHROMA_422(1'b1)) dut422 (.clk_i(clk), .rst_n_i(rst_n), .io(b));

  always #5 clk = ~clk;

  // one clock with the given inputs; history shows what should appear at the outputs
  task automatic step(input logic v_in, input logic d_in, input logic [23:0] p);
    vs = v_in;
    de = d_in;
    rgb = p;
    @(posedge clk);
    #1;
    vs_h = {vs_h[1:0], v_in};
    de_h = {de_h[1:0], d_in};
    if (!rst_n) begin
      vs_h = '0;
      de_h = '0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b1, 1'b1, 24'hFF0000);
    n_chk++;
    if ({a.vs_o, a.de_o, a.y_ch_o, a.u_ch_o, a.v_ch_o} !== {2'b00, 24'h008080}) begin
      n_fail++;
      $display("FAIL reset_444 got %h want %h", {a.vs_o, a.de_o, a.y_ch_o, a.u_ch_o, a.v_ch_o}, {2'b00, 24'h008080});
    end
    n_chk++;
    if ({b.vs_o, b.de_o, b.y_ch_o, b.u_ch_o, b.v_ch_o} !== {2'b00, 24'h008080}) begin
      n_fail++;
      $display("FAIL reset_422 got %h want %h", {b.vs_o, b.de_o, b.y_ch_o, b.u_ch_o, b.v_ch_o}, {2'b00, 24'h008080});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 24'h0);
  endtask

  task automatic test_pixels();
    logic [23:0] pin [6];
    logic [23:0] pexp [6];
    pin = '{24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h102030};
    pexp = '{24'h008080, 24'hFF8080, 24'h4D55FF, 24'h952B15, 24'h1DFF6B, 24'h1D8B77};
    for (int i = 0; i < 8; i++) begin
      step(1'b0, i < 6, (i < 6) ? pin[i] : 24'h0);
      if (i >= 2) begin
        n_chk++;
        if ({a.de_o, a.y_ch_o, a.u_ch_o, a.v_ch_o} !== {1'b1, pexp[i-2]}) begin
          n_fail++;
          $display("FAIL pixel%0d got %h want %h", i - 2, {a.de_o, a.y_ch_o, a.u_ch_o, a.v_ch_o}, {1'b1, pexp[i-2]});
        end
      end
    end
    step(1'b0, 1'b0, 24'h0);
    n_chk++;
    if ({a.de_o, a.y_ch_o, a.u_ch_o, a.v_ch_o} !== {1'b0, 24'h008080}) begin
      n_fail++;
      $display("FAIL blank_after_burst got %h want %h", {a.de_o, a.y_ch_o, a.u_ch_o, a.v_ch_o}, {1'b0, 24'h008080});
    end
  endtask

  task automatic test_timing();
    logic [7:0] cb, lb;
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < 1300; c++) begin
        cb = c[7:0];
        lb = l[7:0];
        step((l == 0 && c < 4) || (l == 1 && c == 700), c >= 20, (c >= 20) ? {cb, lb, 8'h5A} : 24'h0);
        n_chk++;
        if ({a.vs_o, a.de_o, b.vs_o, b.de_o} !== {vs_h[2], de_h[2], vs_h[2], de_h[2]}) begin
          n_fail++;
          $display("FAIL align l%0d c%0d got %b want %b", l, c, {a.vs_o, a.de_o, b.vs_o, b.de_o}, {vs_h[2], de_h[2], vs_h[2], de_h[2]});
        end
        if (!de_h[2]) begin
          n_chk++;
          if ({a.y_ch_o, a.u_ch_o, a.v_ch_o, b.y_ch_o, b.u_ch_o, b.v_ch_o} !== {24'h008080, 24'h008080}) begin
            n_fail++;
            $display("FAIL blanking l%0d c%0d got %h", l, c, {a.y_ch_o, a.u_ch_o, a.v_ch_o, b.y_ch_o, b.u_ch_o, b.v_ch_o});
          end
        end
      end
    end
  endtask

  task automatic test_422();
    logic [12:0] dseq;
    logic [7:0] uexp [13];
    dseq = 13'b0_0000_0011_1101_1111;
    uexp = '{8'hFF, 8'h6B, 8'hFF, 8'h6B, 8'hFF, 8'h80, 8'hFF, 8'h6B, 8'hFF, 8'h6B, 8'h80, 8'h80, 8'h80};
    for (int i = 0; i < 15; i++) begin
      step(1'b0, (i < 13) ? dseq[i] : 1'b0, 24'h0000FF);
      if (i >= 2) begin
        n_chk++;
        if ({b.de_o, b.y_ch_o, b.u_ch_o, b.v_ch_o} !== {dseq[i-2], dseq[i-2] ? 8'h1D : 8'h00, uexp[i-2], 8'h80}) begin
          n_fail++;
          $display("FAIL chroma422_px%0d got %h want %h", i - 2, {b.de_o, b.y_ch_o, b.u_ch_o, b.v_ch_o}, {dseq[i-2], dseq[i-2] ? 8'h1D : 8'h00, uexp[i-2], 8'h80});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 24'hFF0000);
    rst_n = 1'b0;
    step(1'b0, 1'b1, 24'hFF0000);
    n_chk++;
    if ({a.de_o, a.y_ch_o, a.u_ch_o, a.v_ch_o, b.de_o, b.u_ch_o} !== {1'b0, 24'h008080, 1'b0, 8'h80}) begin
      n_fail++;
      $display("FAIL reset_mid got %h want %h", {a.de_o, a.y_ch_o, a.u_ch_o, a.v_ch_o, b.de_o, b.u_ch_o}, {1'b0, 24'h008080, 1'b0, 8'h80});
    end
    rst_n = 1'b1;
    for (int j = 1; j < 7; j++) begin
      step(1'b0, 1'b1, 24'h00FF00);
      n_chk++;
      if ({a.de_o, a.y_ch_o, a.u_ch_o, a.v_ch_o} !== ((j < 3) ? {1'b0, 24'h008080} : {1'b1, 24'h952B15})) begin
        n_fail++;
        $display("FAIL post_reset_444 j%0d got %h want %h", j, {a.de_o, a.y_ch_o, a.u_ch_o, a.v_ch_o}, (j < 3) ? {1'b0, 24'h008080} : {1'b1, 24'h952B15});
      end
      n_chk++;
      if ({b.de_o, b.y_ch_o, b.u_ch_o, b.v_ch_o} !== ((j < 3) ? {1'b0, 24'h008080} : {1'b1, 8'h95, (j % 2 == 1) ? 8'h2B : 8'h15, 8'h80})) begin
        n_fail++;
        $display("FAIL post_reset_422 j%0d got %h want %h", j, {b.de_o, b.y_ch_o, b.u_ch_o, b.v_ch_o}, (j < 3) ? {1'b0, 24'h008080} : {1'b1, 8'h95, (j % 2 == 1) ? 8'h2B : 8'h15, 8'h80});
      end
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 24'h0);
  endtask

  initial begin
    test_reset();
    test_pixels();
    test_timing();
    test_422();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
